// File: rtl/spi_slave.sv
// SPI mode 0 slave, MSB first, oversampled in i_clk. Received words come out on a one-cycle
// strobe; transmit words are loaded through a single-entry holding register.
module spi_slave #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sclk,
    input  logic                  i_cs_n,
    input  logic                  i_mosi,
    output logic                  o_miso,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_busy
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic       sclk_hist_q, cs_hist_q;

    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] tx_hold_q, tx_hold_d;
    logic                  tx_pend_q, tx_pend_d;
    logic                  word_done_q, word_done_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;

    logic                  sel, sclk_rise, cs_fall, last_bit, load;
    logic [DATA_WIDTH-1:0] tx_word;

    // MOSI shares the SCLK sync depth so the sampled bit lines up with the detected edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_sync_q <= 2'b00;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], i_sclk};
            cs_sync_q   <= {cs_sync_q[0], i_cs_n};
            mosi_sync_q <= {mosi_sync_q[0], i_mosi};
            sclk_hist_q <= sclk_sync_q[1];
            cs_hist_q   <= cs_sync_q[1];
        end
    end

    always_comb begin
        sel       = ~cs_sync_q[1];
        sclk_rise = sel & sclk_sync_q[1] & ~sclk_hist_q;
        cs_fall   = sel & cs_hist_q;
        last_bit  = sclk_rise && (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
        load      = cs_fall | last_bit;
        tx_word   = i_tx_valid ? i_tx_data : (tx_pend_q ? tx_hold_q : '0);

        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_hold_d   = tx_hold_q;
        tx_pend_d   = tx_pend_q;
        word_done_d = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;

        if (i_tx_valid) begin
            tx_hold_d = i_tx_data;
            tx_pend_d = 1'b1;
        end

        if (!sel) begin
            bit_cnt_d  = '0;
            tx_shift_d = '0;
        end else begin
            if (sclk_rise) begin
                rx_shift_d  = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync_q[1]};
                tx_shift_d  = tx_shift_q << 1;
                bit_cnt_d   = last_bit ? '0 : bit_cnt_q + CNT_W'(1);
                word_done_d = last_bit;
            end
            // a load wins over the shift; a coincident tx strobe bypasses the holding register
            if (load) begin
                tx_shift_d = tx_word;
                tx_pend_d  = 1'b0;
            end
        end

        if (word_done_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            tx_hold_q   <= '0;
            tx_pend_q   <= 1'b0;
            word_done_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_hold_q   <= tx_hold_d;
            tx_pend_q   <= tx_pend_d;
            word_done_q <= word_done_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    assign o_miso     = sel & tx_shift_q[DATA_WIDTH-1];
    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
    assign o_busy     = sel;
endmodule

// File: tb/tb_spi_slave.sv
// Drives spi_slave as an SPI mode 0 master and checks MISO bits and received strobes
// against a word-level model of the holding register and the frame.
module tb_spi_slave;
    localparam int HALF = 40;

    logic       i_clk = 1'b0, i_rst_n = 1'b0;
    logic       i_sclk = 1'b0, i_cs_n = 1'b1, i_mosi = 1'b0;
    logic       o_miso, o_rx_valid, o_busy, i_tx_valid = 1'b0;
    logic [7:0] o_rx_data, i_tx_data = 8'h00;

    spi_slave #(.DATA_WIDTH(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sclk(i_sclk), .i_cs_n(i_cs_n),
        .i_mosi(i_mosi), .o_miso(o_miso), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
        .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0, n_err = 0, pulse_err = 0;
    logic [7:0] got_rx[$], exp_rx[$];
    logic prev_vld = 1'b0;

    // model state: single-entry holding register
    logic       m_pend = 1'b0;
    logic [7:0] m_held = 8'h00, m_last_rx = 8'h00;
    logic [7:0] fr_mosi [4];

    always @(negedge i_clk) begin
        if (o_rx_valid) got_rx.push_back(o_rx_data);
        if (o_rx_valid && prev_vld) pulse_err++;
        prev_vld <= o_rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tx_write(input logic [7:0] v);
        i_tx_data  = v;
        i_tx_valid = 1'b1;
        #10;
        i_tx_valid = 1'b0;
        m_held = v;
        m_pend = 1'b1;
    endtask

    // shifts nb bits MSB first; returns the MISO bits the master sampled at each rising edge
    task automatic spi_word(input logic [7:0] mw, input int nb, output logic [7:0] sm);
        sm = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            i_mosi = mw[i];
            #HALF;
            sm[i] = o_miso;
            i_sclk = 1'b1;
            #HALF;
            i_sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int n, input bit mid_wr, input logic [7:0] mid_val);
        logic [7:0] sm, expw;
        i_cs_n = 1'b0;
        #(4 * HALF);
        chk("busy_in_frame", o_busy, 1);
        fork
            for (int w = 0; w < n; w++) begin
                expw   = m_pend ? m_held : 8'h00;
                m_pend = 1'b0;
                spi_word(fr_mosi[w], 8, sm);
                chk($sformatf("miso_w%0d", w), sm, expw);
                exp_rx.push_back(fr_mosi[w]);
                m_last_rx = fr_mosi[w];
            end
            begin
                if (mid_wr) begin
                    #200;
                    tx_write(mid_val);
                end
            end
        join
        #(2 * HALF);
        i_cs_n = 1'b1;
        #(4 * HALF);
        chk("busy_after_frame", o_busy, 0);
        chk("miso_deselected", o_miso, 0);
    endtask

    task automatic check_rx(input string tag);
        #100;
        chk({tag, "_count"}, got_rx.size(), exp_rx.size());
        while (got_rx.size() > 0 && exp_rx.size() > 0)
            chk({tag, "_data"}, got_rx.pop_front(), exp_rx.pop_front());
        got_rx.delete();
        exp_rx.delete();
    endtask

    initial begin
        logic [7:0] sm, expw;
        #30;
        chk("rst_miso", o_miso, 0);
        chk("rst_rx_data", o_rx_data, 0);
        chk("rst_rx_valid", o_rx_valid, 0);
        chk("rst_busy", o_busy, 0);
        i_rst_n = 1'b1;
        #100;

        // directed frames
        tx_write(8'h5A); fr_mosi[0] = 8'hA5; run_frame(1, 0, 8'h00); check_rx("basic");
        tx_write(8'h34); fr_mosi[0] = 8'h12; run_frame(1, 0, 8'h00);
        tx_write(8'hCD); fr_mosi[0] = 8'hAB; run_frame(1, 0, 8'h00); check_rx("two_frames");
        tx_write(8'h00); fr_mosi[0] = 8'hFF; run_frame(1, 0, 8'h00);
        tx_write(8'hFF); fr_mosi[0] = 8'h00; run_frame(1, 0, 8'h00); check_rx("extremes");
        tx_write(8'h11);
        fr_mosi[0] = 8'hC3; fr_mosi[1] = 8'h3C; fr_mosi[2] = 8'h5E;
        run_frame(3, 1, 8'h22); check_rx("multi_word");
        chk("rx_data_hold", o_rx_data, m_last_rx);

        // abort after 5 bits, then a complete frame
        tx_write(8'h77);
        i_cs_n = 1'b0;
        #(4 * HALF);
        expw = m_pend ? m_held : 8'h00;
        m_pend = 1'b0;
        spi_word(8'hAA, 5, sm);
        chk("abort_miso", sm[7:3], expw[7:3]);
        #HALF;
        i_cs_n = 1'b1;
        #(4 * HALF);
        fr_mosi[0] = 8'h96; run_frame(1, 0, 8'h00); check_rx("abort");

        // randomized frames
        for (int it = 0; it < 10; it++) begin
            int nw, nwr;
            nw  = $urandom_range(1, 3);
            nwr = $urandom_range(0, 2);
            for (int k = 0; k < nwr; k++) tx_write(8'($urandom));
            for (int w = 0; w < nw; w++) fr_mosi[w] = 8'($urandom);
            run_frame(nw, $urandom_range(0, 1) == 1, 8'($urandom));
        end
        check_rx("random");

        // free-running SCLK while deselected
        for (int c = 0; c < 20; c++) begin
            i_mosi = 1'($urandom);
            #HALF; i_sclk = 1'b1;
            #HALF; i_sclk = 1'b0;
            if (c % 5 == 0) chk("freerun_miso", o_miso, 0);
        end
        check_rx("freerun");
        chk("freerun_rx_data", o_rx_data, m_last_rx);
        chk("freerun_busy", o_busy, 0);

        // reset mid-word
        tx_write(8'hE7);
        i_cs_n = 1'b0;
        #(4 * HALF);
        spi_word(8'h5B, 4, sm);
        i_rst_n = 1'b0;
        m_pend = 1'b0; m_held = 8'h00; m_last_rx = 8'h00;
        #10;
        chk("midrst_miso", o_miso, 0);
        chk("midrst_rx_data", o_rx_data, m_last_rx);
        chk("midrst_busy", o_busy, 0);
        i_cs_n = 1'b1;
        #40;
        i_rst_n = 1'b1;
        #100;
        chk("postrst_rx_valid", o_rx_valid, 0);
        chk("postrst_rx_data", o_rx_data, 0);
        check_rx("reset");
        // pending word was cleared by reset, so the next frame sends zeros
        fr_mosi[0] = 8'h3D; run_frame(1, 0, 8'h00); check_rx("after_reset");

        chk("pulse_width", pulse_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
